// File: rtl/mire_pkg.sv
// mire_pkg: shared types and bar colours for the test-pattern framebuffer writer
package mire_pkg;
  typedef enum logic [1:0] {IDLE, WRITE, PAUSE} state_t;
  typedef enum logic [1:0] {GRID, BARS, GRADIENT, SOLID} pattern_t;
  localparam logic [7:0][23:0] BAR_RGB = {
    24'h000000, 24'h0000FF, 24'hFF0000, 24'hFF00FF,
    24'h00FF00, 24'h00FFFF, 24'hFFFF00, 24'hFFFFFF
  };
endpackage

// File: rtl/wshb_if.sv
// wshb_if: Wishbone bus shared by the framebuffer reader and writer
interface wshb_if (input logic clk, input logic rst);
  logic [31:0] adr;
  logic [31:0] dat_ms;
  logic        we;
  logic [3:0]  sel;
  logic        stb;
  logic        cyc;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        ack;
  modport master (input clk, rst, ack, output adr, dat_ms, we, sel, stb, cyc, cti, bte);
  modport slave (input clk, rst, adr, dat_ms, we, sel, stb, cyc, cti, bte, output ack);
endinterface

// File: rtl/mire_pixel_gen.sv
// mire_pixel_gen: combinational RGB of one test-pattern pixel
module mire_pixel_gen import mire_pkg::*; #(
  parameter int XW = 10,
  parameter int YW = 9,
  parameter int GRID_STEP = 16
) (
  input  logic [XW-1:0] x,
  input  logic [YW-1:0] y,
  input  logic [2:0]    bar,
  input  pattern_t      pattern,
  output logic [23:0]   rgb
);
  logic on_grid;
  logic [7:0] lum;
  always_comb begin
    on_grid = (32'(x) & 32'(GRID_STEP - 1)) == 32'd0 || (32'(y) & 32'(GRID_STEP - 1)) == 32'd0;
    lum = 8'(x);
    rgb = pattern == GRID ? (on_grid ? 24'hFFFFFF : 24'h000000)
        : pattern == BARS ? BAR_RGB[bar]
        : pattern == GRADIENT ? {3{lum}}
        : 24'hFF0000;
  end
endmodule

// File: rtl/mire_writer.sv
// mire_writer: Wishbone master writing one test-pattern frame into the framebuffer,
// releasing cyc for one cycle after every BURST_LEN writes so the reader can be served.
module mire_writer import mire_pkg::*; #(
  parameter int HDISP = 800,
  parameter int VDISP = 480,
  parameter int BURST_LEN = 64,
  parameter int GRID_STEP = 16
) (
  wshb_if.master     wshb_ifm,
  input  logic       start,
  input  logic [1:0] pattern,
  output logic       busy,
  output logic       frame_done
);
  localparam int XW = HDISP > 1 ? $clog2(HDISP) : 1;
  localparam int YW = VDISP > 1 ? $clog2(VDISP) : 1;
  localparam int BW = $clog2(BURST_LEN + 1);
  localparam int BAR_W = HDISP / 8 > 0 ? HDISP / 8 : 1;
  state_t state_q, state_d;
  pattern_t pat_q, pat_d;
  logic [XW-1:0] x_q, x_d, bar_cnt_q, bar_cnt_d;
  logic [YW-1:0] y_q, y_d;
  logic [2:0] bar_q, bar_d;
  logic [BW-1:0] burst_q, burst_d;
  logic [31:0] adr_q, adr_d, dat_q, dat_d;
  logic frame_done_q, frame_done_d;
  logic go, ack_ok, x_last, last, bar_last, burst_last;
  logic [23:0] rgb;
  always_comb begin
    go = state_q == IDLE && start;
    ack_ok = state_q == WRITE && wshb_ifm.ack;
    x_last = x_q == XW'(HDISP - 1);
    last = x_last && y_q == YW'(VDISP - 1);
    bar_last = bar_cnt_q == XW'(BAR_W - 1);
    burst_last = burst_q == BW'(BURST_LEN - 1);
    x_d = go || (ack_ok && x_last) ? '0 : ack_ok ? x_q + XW'(1) : x_q;
    y_d = go ? '0 : ack_ok && x_last ? y_q + YW'(1) : y_q;
    bar_cnt_d = go || (ack_ok && (x_last || bar_last)) ? '0 : ack_ok ? bar_cnt_q + XW'(1) : bar_cnt_q;
    // the last bar absorbs any remainder pixels, so the bar index saturates at 7
    bar_d = go || (ack_ok && x_last) ? '0 : ack_ok && bar_last && bar_q != 3'd7 ? bar_q + 3'd1 : bar_q;
    burst_d = go || (ack_ok && burst_last) ? '0 : ack_ok ? burst_q + BW'(1) : burst_q;
    adr_d = go ? '0 : ack_ok ? adr_q + 32'd4 : adr_q;
    pat_d = go ? pattern_t'(pattern) : pat_q;
    frame_done_d = ack_ok && last;
    state_d = go || state_q == PAUSE ? WRITE
            : ack_ok && last ? IDLE
            : ack_ok && burst_last ? PAUSE
            : state_q;
  end
  mire_pixel_gen #(.XW(XW), .YW(YW), .GRID_STEP(GRID_STEP)) u_pix (
    .x(x_d), .y(y_d), .bar(bar_d), .pattern(pat_d), .rgb(rgb)
  );
  // data is computed for the next pixel so it is registered alongside its address
  always_comb dat_d = go || ack_ok ? {8'h00, rgb} : dat_q;
  always_ff @(posedge wshb_ifm.clk) begin
    if (wshb_ifm.rst) begin
      state_q <= IDLE;
      pat_q <= GRID;
      x_q <= '0;
      y_q <= '0;
      bar_cnt_q <= '0;
      bar_q <= '0;
      burst_q <= '0;
      adr_q <= '0;
      dat_q <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q <= pat_d;
      x_q <= x_d;
      y_q <= y_d;
      bar_cnt_q <= bar_cnt_d;
      bar_q <= bar_d;
      burst_q <= burst_d;
      adr_q <= adr_d;
      dat_q <= dat_d;
      frame_done_q <= frame_done_d;
    end
  end
  assign wshb_ifm.adr = adr_q;
  assign wshb_ifm.dat_ms = dat_q;
  assign wshb_ifm.we = 1'b1;
  assign wshb_ifm.sel = 4'b1111;
  assign wshb_ifm.cti = 3'b000;
  assign wshb_ifm.bte = 2'b00;
  assign wshb_ifm.cyc = state_q == WRITE;
  assign wshb_ifm.stb = state_q == WRITE;
  assign busy = state_q != IDLE;
  assign frame_done = frame_done_q;
endmodule

// File: tb/tb_mire_writer.sv
// tb_mire_writer: scoreboard bench over three writer configurations sharing clock and reset
module tb_mire_writer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] start = '0;
  logic [2:0][1:0] pat = '0;
  logic [2:0] rnd_ack = '0;
  logic [2:0] busy, fd;
  int n_chk = 0;
  int n_pass = 0;
  always #5 clk = ~clk;
  wshb_if bus[3] (.clk(clk), .rst(rst));
  mire_writer #(.HDISP(16), .VDISP(4), .BURST_LEN(64)) u0 (
    .wshb_ifm(bus[0]), .start(start[0]), .pattern(pat[0]), .busy(busy[0]), .frame_done(fd[0]));
  mire_writer #(.HDISP(800), .VDISP(2), .BURST_LEN(64)) u1 (
    .wshb_ifm(bus[1]), .start(start[1]), .pattern(pat[1]), .busy(busy[1]), .frame_done(fd[1]));
  mire_writer #(.HDISP(16), .VDISP(4), .BURST_LEN(4)) u2 (
    .wshb_ifm(bus[2]), .start(start[2]), .pattern(pat[2]), .busy(busy[2]), .frame_done(fd[2]));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [23:0] ref_rgb(input int p, input int x, input int y, input int h);
    int b;
    logic [7:0] g;
    b = x / (h / 8);
    if (b > 7) b = 7;
    g = 8'(x);
    case (p)
      0: return (x % 16 == 0 || y % 16 == 0) ? 24'hFFFFFF : 24'h000000;
      1: case (b)
           0: return 24'hFFFFFF;
           1: return 24'hFFFF00;
           2: return 24'h00FFFF;
           3: return 24'h00FF00;
           4: return 24'hFF00FF;
           5: return 24'hFF0000;
           6: return 24'h0000FF;
           default: return 24'h000000;
         endcase
      2: return {g, g, g};
      default: return 24'hFF0000;
    endcase
  endfunction

  for (genvar g = 0; g < 3; g++) begin : mon
    localparam int H = g == 1 ? 800 : 16;
    localparam int V = g == 1 ? 2 : 4;
    localparam int BL = g == 2 ? 4 : 64;
    localparam int CA = g == 1 ? 400 : 4;
    localparam int CB = g == 1 ? 3196 : 68;
    logic [63:0] q[$];
    logic mbusy = 1'b0, exp_cyc = 1'b0, exp_busy = 1'b0, exp_fd = 1'b0, hold = 1'b0;
    logic [31:0] hadr = '0, hdat = '0, w_a = '0, w_b = '0, ladr = '0;
    int tcnt = 0, beats = 0, fbeats = 0, dcnt = 0, pz = 0, bcy = 0;
    always @(negedge clk) begin
      logic a, pz_now;
      logic [63:0] e;
      if (rst) begin
        q.delete();
        mbusy = 1'b0; exp_cyc = 1'b0; exp_busy = 1'b0; exp_fd = 1'b0; hold = 1'b0; tcnt = 0;
        bus[g].ack = 1'($urandom_range(0, 1));
      end else begin
        chk("cyc", 64'(bus[g].cyc), 64'(exp_cyc));
        chk("stb", 64'(bus[g].stb), 64'(exp_cyc));
        chk("busy", 64'(busy[g]), 64'(exp_busy));
        if (fd[g] || exp_fd) chk("frame_done", 64'(fd[g]), 64'(exp_fd));
        if (hold && bus[g].stb) chk("stall_hold", {bus[g].adr, bus[g].dat_ms}, {hadr, hdat});
        if (busy[g]) bcy++;
        if (busy[g] && !bus[g].cyc) pz++;
        if (fd[g]) dcnt++;
        exp_fd = 1'b0;
        pz_now = 1'b0;
        if (start[g] && !mbusy) begin
          for (int y = 0; y < V; y++)
            for (int x = 0; x < H; x++)
              q.push_back({32'(4 * (y * H + x)), 8'h00, ref_rgb(int'(pat[g]), x, y, H)});
          mbusy = 1'b1; tcnt = 0; fbeats = 0;
        end
        a = rnd_ack[g] ? $urandom_range(0, 3) != 0 : 1'b1;
        if (bus[g].cyc && bus[g].stb && a) begin
          if (q.size() == 0) chk("extra_beat", {bus[g].adr, bus[g].dat_ms}, 64'hFFFF_FFFF_FFFF_FFFF);
          else begin
            e = q.pop_front();
            chk("beat", {bus[g].adr, bus[g].dat_ms}, e);
          end
          if (bus[g].adr == CA) w_a = bus[g].dat_ms;
          if (bus[g].adr == CB) w_b = bus[g].dat_ms;
          ladr = bus[g].adr;
          beats++; fbeats++; tcnt++;
          if (q.size() == 0) begin
            mbusy = 1'b0; exp_fd = 1'b1;
          end else if (tcnt == BL) begin
            tcnt = 0; pz_now = 1'b1;
          end
        end
        hold = bus[g].stb && !a;
        hadr = bus[g].adr;
        hdat = bus[g].dat_ms;
        exp_cyc = mbusy && !pz_now;
        exp_busy = mbusy;
        bus[g].ack = a;
      end
    end
  end

  initial begin
    int p0, c0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cyc", 64'(bus[0].cyc), 0);
    chk("rst_stb", 64'(bus[2].stb), 0);
    chk("rst_adr", 64'(bus[0].adr), 0);
    chk("rst_dat", 64'(bus[1].dat_ms), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_fd", 64'(fd), 0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (100) @(posedge clk);
    chk("idle_beats", 64'(mon[0].beats + mon[1].beats + mon[2].beats), 0);
    // grid frame, ack always high
    #1 pat[0] = 2'd0; start[0] = 1'b1;
    @(posedge clk); #1 start[0] = 1'b0;
    for (int i = 0; i < 1000 && mon[0].dcnt < 1; i++) @(posedge clk);
    chk("grid_done", 64'(mon[0].dcnt), 1);
    chk("grid_beats", 64'(mon[0].beats), 64);
    chk("grid_last_adr", 64'(mon[0].ladr), 252);
    chk("grid_adr4", 64'(mon[0].w_a), 64'h00FFFFFF);
    chk("grid_adr68", 64'(mon[0].w_b), 64'h00000000);
    // colour bars, random ack stalls
    #1 rnd_ack[1] = 1'b1; pat[1] = 2'd1; start[1] = 1'b1;
    @(posedge clk); #1 start[1] = 1'b0;
    for (int i = 0; i < 8000 && mon[1].dcnt < 1; i++) @(posedge clk);
    chk("bars_done", 64'(mon[1].dcnt), 1);
    chk("bars_beats", 64'(mon[1].beats), 1600);
    chk("bars_last_adr", 64'(mon[1].ladr), 6396);
    chk("bars_x100", 64'(mon[1].w_a), 64'h00FFFF00);
    chk("bars_x799", 64'(mon[1].w_b), 64'h00000000);
    // short bursts; start and pattern change mid-frame must be ignored
    p0 = mon[2].pz; c0 = mon[2].bcy;
    #1 pat[2] = 2'd2; start[2] = 1'b1;
    @(posedge clk); #1 start[2] = 1'b0;
    repeat (10) @(posedge clk);
    #1 pat[2] = 2'd3; start[2] = 1'b1;
    @(posedge clk); #1 start[2] = 1'b0;
    for (int i = 0; i < 500 && mon[2].dcnt < 1; i++) @(posedge clk);
    chk("burst_done", 64'(mon[2].dcnt), 1);
    chk("burst_beats", 64'(mon[2].beats), 64);
    chk("burst_pauses", 64'(mon[2].pz - p0), 15);
    chk("burst_cycles", 64'(mon[2].bcy - c0), 79);
    // start held high: ignored on the final ack, accepted alongside frame_done
    #1 start[0] = 1'b1;
    for (int i = 0; i < 1000 && mon[0].dcnt < 3; i++) @(posedge clk);
    #1 start[0] = 1'b0;
    for (int i = 0; i < 1000 && mon[0].dcnt < 4; i++) @(posedge clk);
    repeat (5) @(posedge clk);
    chk("b2b_done", 64'(mon[0].dcnt), 4);
    chk("b2b_beats", 64'(mon[0].beats), 256);
    // reset mid-frame, then restart from address 0
    #1 pat[2] = 2'd0; start[2] = 1'b1;
    @(posedge clk); #1 start[2] = 1'b0;
    for (int i = 0; i < 200 && mon[2].fbeats < 37; i++) @(posedge clk);
    chk("mid_beats", 64'(mon[2].fbeats), 37);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_cyc", 64'(bus[2].cyc), 0);
    chk("mid_rst_adr", 64'(bus[2].adr), 0);
    chk("mid_rst_busy", 64'(busy[2]), 0);
    chk("mid_rst_dat", 64'(bus[2].dat_ms), 0);
    repeat (3) @(posedge clk);
    #1 pat[2] = 2'd3; start[2] = 1'b1;
    @(posedge clk); #1 start[2] = 1'b0;
    for (int i = 0; i < 500 && mon[2].dcnt < 2; i++) @(posedge clk);
    chk("restart_done", 64'(mon[2].dcnt), 2);
    chk("restart_beats", 64'(mon[2].fbeats), 64);
    repeat (5) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mire_writer.md
# mire_writer

- Wishbone master that writes one full test-pattern frame (HDISP×VDISP pixels, 32-bit word per pixel) into the framebuffer.
- Acts as the writer counterpart of the VGA framebuffer reader: shares the same `wshb_if` bus and byte-address layout, `adr = 4*(y*HDISP + x)`.
- Releases `cyc` periodically so the bus arbiter can serve the VGA reader without starving its FIFO.

## Interface
Parameters:
- `HDISP`, 800: image width in pixels
- `VDISP`, 480: image height in pixels
- `BURST_LEN`, 64: writes per bus tenure before `cyc` is released
- `GRID_STEP`, 16: grid line spacing in pixels; power of two, at least 2

Ports:
- `wshb_ifm.clk`  in  1: single clock, carried in the interface
- `wshb_ifm.rst`  in  1: reset, synchronous, active-high, carried in the interface
- `wshb_ifm`  master  wshb_if: `adr`, `dat_ms`, `we`, `sel`, `stb`, `cyc`, `cti`, `bte` driven; `ack` sampled
- `start`  in  1: one-cycle request to write a frame; ignored while `busy`
- `pattern`  in  2: pattern select, sampled only when `start` is accepted
- `busy`  out  1: high from the cycle after `start` is accepted until the frame is finished
- `frame_done`  out  1: one-cycle pulse after the last pixel is acknowledged

## Operation
- Constant outputs:
  - `we=1`, `sel=4'b1111`, `cti=3'b000`, `bte=2'b00`
  - `dat_ms[31:24]=8'h00`, `dat_ms[23:0]` = RGB of the current pixel
- State machine:
  - IDLE → WRITE: on `start`. Clear `x`, `y`, `adr`, `burst_cnt`; latch `pattern`.
  - WRITE: `cyc=stb=1`. On each `ack`:
    - advance `x`; on `x==HDISP-1`, set `x=0` and `y++`;
    - `adr += 4`;
    - `burst_cnt++`.
  - WRITE → IDLE: on `ack` of the pixel (HDISP-1, VDISP-1). Pulse `frame_done`.
  - WRITE → PAUSE: on `ack` that makes `burst_cnt == BURST_LEN`, when it is not the last pixel. Clear `burst_cnt`.
  - PAUSE: `cyc=stb=0` for exactly 1 cycle, then WRITE.
- Patterns, a function of (x, y):
  - 0, grid: 24'hFFFFFF if `x%GRID_STEP==0` or `y%GRID_STEP==0`; else 24'h000000.
  - 1, colour bars: 8 bars, each HDISP/8 wide, left to right: FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
    - Bar index comes from a bar-width counter, not a divider.
    - Remainder pixels when HDISP is not a multiple of 8 belong to bar 7.
  - 2, gradient: R=G=B=`x[7:0]`.
  - 3, solid red: 24'hFF0000.
- Widths:
  - `adr` is 32 bits.
  - `x` uses $clog2(HDISP) bits; `y` uses $clog2(VDISP) bits.
  - Last address is 4*(HDISP*VDISP-1), which is 1535996 at the defaults.

## Timing
- Reset values:
  - `cyc=stb=0`, `adr=0`, `dat_ms=32'h0`
  - `busy=0`, `frame_done=0`, state IDLE
- Start latency: `start` high at cycle t → `cyc=stb=1` with `adr=0` and pixel (0,0) data at t+1.
- Handshake:
  - `adr` and `dat_ms` are registered and stay stable while `stb` is high without `ack`.
  - They update on the clock edge where `ack=1`.
  - Same-cycle `ack` is legal, so one write per cycle is sustained.
- `ack` while `stb=0` (IDLE or PAUSE) is ignored.
- `busy` is high in WRITE and PAUSE only.
- `frame_done` is high for exactly the cycle following the final `ack`, with state IDLE.
- `start` coincident with the final `ack` is ignored; `start` is accepted only in IDLE.
- A new `start` in the same cycle as `frame_done` is accepted.
- Reset mid-frame: the next cycle is IDLE with all outputs at reset values. Nothing resumes.
- Full frame at 1 write/cycle takes HDISP*VDISP + floor((HDISP*VDISP-1)/BURST_LEN) cycles from the first `stb` to the last `ack`.

## Structure
- Shared package `mire_pkg`:
  - state enum: IDLE, WRITE, PAUSE
  - pattern enum: GRID, BARS, GRADIENT, SOLID
  - 24-bit colour constants for the eight bars
- Sub-module `mire_pixel_gen`: combinational (x, y, bar index, pattern) → RGB.
- The top level holds the FSM, pixel/row/bar counters, burst counter and address register.

## Test plan
- Reset → `cyc=0`, `adr=0`, `busy=0`; hold `start` low for 100 cycles → no bus activity.
- Grid pattern with HDISP=16, VDISP=4, `ack` always 1:
  - 64 writes, `adr` from 0 to 252;
  - word at `adr=4` is 32'h00FFFFFF (y=0) and at `adr=68` is 32'h00000000;
  - `frame_done` pulses once.
- Bars with default size, random `ack` stalls:
  - `adr`/`dat_ms` held during stalls;
  - pixel x=100 is 32'h00FFFF00 and x=799 is 32'h00000000.
- BURST_LEN=4 with `ack` always 1 → `cyc` low for 1 cycle after every 4th `ack`, never after the final one.
- `start` pulsed during WRITE, and with `pattern` changed mid-frame → ignored; the frame finishes with the latched pattern.
- `rst` asserted at pixel 37 → next cycle IDLE, `cyc=0`, `adr=0`; a new `start` restarts at `adr=0`.
